// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants for the round-robin mux arbiter.
package rr_mux_pkg;
  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;
  localparam int DEF_WIDTH = 8;
  localparam int STATS_W = 16;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin grant with the last_grant flop.
// last_grant only moves on a handshake, so a waiting source keeps its grant.
module rr_grant
  import rr_mux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i0_valid,
  input  logic i1_valid,
  input  logic i_hs,
  output logic o_grant
);
  logic r_last;
  always_comb o_grant = (i0_valid && i1_valid) ? ~r_last :
                        i0_valid ? SRC_I0 :
                        i1_valid ? SRC_I1 : r_last;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last <= SRC_I1;
    else if (i_hs) r_last <= o_grant;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: two-input round-robin arbiter driving a 2:1 mux select, with a registered output stage.
// Define RR_MUX_ARBITER_STATS_EN to add per-source handshake counters cnt0/cnt1.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
`ifdef RR_MUX_ARBITER_STATS_EN
  ,
  output logic [STATS_W-1:0] cnt0,
  output logic [STATS_W-1:0] cnt1
`endif
);
  logic w_grant, w_accept, w_hs;
  logic r_out_valid, r_out_src;
  logic [WIDTH-1:0] r_out_data;
  rr_grant u_grant (
    .clk      (clk),
    .rst      (rst),
    .i0_valid (i0_valid),
    .i1_valid (i1_valid),
    .i_hs     (w_hs),
    .o_grant  (w_grant)
  );
  // the output stage may load in the same cycle it drains
  assign w_accept  = !r_out_valid || out_ready;
  assign i0_ready  = w_accept && i0_valid && (w_grant == SRC_I0);
  assign i1_ready  = w_accept && i1_valid && (w_grant == SRC_I1);
  assign w_hs      = i0_ready || i1_ready;
  assign sel       = w_grant;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= SRC_I0;
    end else if (w_hs) begin
      r_out_valid <= 1'b1;
      r_out_data  <= (w_grant == SRC_I1) ? i1_data : i0_data;
      r_out_src   <= w_grant;
    end else if (out_ready) r_out_valid <= 1'b0;
`ifdef RR_MUX_ARBITER_STATS_EN
  logic [STATS_W-1:0] r_cnt0, r_cnt1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (i0_ready) r_cnt0 <= r_cnt0 + 1'b1;
      if (i1_ready) r_cnt1 <= r_cnt1 + 1'b1;
    end
  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: table vectors, hand sequences and a random run against a reference model.
module tb_rr_mux_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic i0_valid = 0, i1_valid = 0, out_ready = 0;
  logic [7:0] i0_data = 0, i1_data = 0;
  logic i0_ready, i1_ready, sel, out_valid, out_src;
  logic [7:0] out_data;
`ifdef RR_MUX_ARBITER_STATS_EN
  logic [15:0] cnt0, cnt1, m_c0, m_c1;
`endif
  int n_cmp = 0, n_err = 0;
  logic m_ov, m_os, m_last;
  logic [7:0] m_od;

  rr_mux_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
`ifdef RR_MUX_ARBITER_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic ordy;
    logic e_sel, e_r0, e_r1, e_ov; logic [7:0] e_od; logic e_os;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_od = 0; m_os = 0; m_last = 1;
`ifdef RR_MUX_ARBITER_STATS_EN
    m_c0 = 0; m_c1 = 0;
`endif
  endtask

  // one model-checked cycle, entered and left on a falling edge
  task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1, input logic ordy);
    logic g, acc, e0, e1;
    i0_valid = v0; i0_data = d0; i1_valid = v1; i1_data = d1; out_ready = ordy;
    #1;
    // whoever went last yields under contention; an idle arbiter keeps pointing at the last winner
    g = (v0 && v1) ? !m_last : v0 ? 1'b0 : v1 ? 1'b1 : m_last;
    acc = !m_ov || ordy;
    e0 = acc && v0 && !g;
    e1 = acc && v1 && g;
    chk("sel", sel, g);
    chk("i0_ready", i0_ready, e0);
    chk("i1_ready", i1_ready, e1);
    if (e0 || e1) begin
      m_ov = 1; m_od = g ? d1 : d0; m_os = g; m_last = g;
`ifdef RR_MUX_ARBITER_STATS_EN
      if (e0) m_c0++; else m_c1++;
`endif
    end else if (ordy) m_ov = 0;
    @(negedge clk);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_data", out_data, m_od);
    if (m_ov) chk("out_src", out_src, m_os);
  endtask

  initial begin
    tbl[0] = '{1, 8'h11, 1, 8'h22, 1, 0, 1, 0, 1, 8'h11, 0};
    tbl[1] = '{1, 8'h11, 1, 8'h22, 1, 1, 0, 1, 1, 8'h22, 1};
    tbl[2] = '{1, 8'h11, 1, 8'h22, 1, 0, 1, 0, 1, 8'h11, 0};
    tbl[3] = '{0, 8'h00, 1, 8'hA5, 1, 1, 0, 1, 1, 8'hA5, 1};
    tbl[4] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'hA5, 1};
    tbl[5] = '{1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 1, 8'hA5, 1};
    tbl[6] = '{1, 8'h11, 1, 8'h22, 1, 0, 1, 0, 1, 8'h11, 0};
    tbl[7] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h11, 0};
    tbl[8] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h11, 0};
    tbl[9] = '{1, 8'h3C, 0, 8'h00, 0, 0, 1, 0, 1, 8'h3C, 0};
    @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_src", out_src, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      i0_valid = tbl[i].v0; i0_data = tbl[i].d0;
      i1_valid = tbl[i].v1; i1_data = tbl[i].d1; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d sel", i), sel, tbl[i].e_sel);
      chk($sformatf("tbl%0d i0_ready", i), i0_ready, tbl[i].e_r0);
      chk($sformatf("tbl%0d i1_ready", i), i1_ready, tbl[i].e_r1);
      @(negedge clk);
      chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].e_od);
      chk($sformatf("tbl%0d out_src", i), out_src, tbl[i].e_os);
    end
    // asynchronous reset in the middle of a cycle while a word is held
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_data", out_data, 0);
    chk("async rst out_src", out_src, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    cyc(1, 8'h11, 1, 8'h22, 1);
    chk("post-rst first grant", m_os, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'h11, 1, 8'h22, 0);
      chk("backpressure hold", out_data, 8'h11);
    end
    cyc(1, 8'h11, 1, 8'h22, 1);
    chk("reload after stall", out_data, 8'h22);
    cyc(0, 8'h00, 0, 8'h00, 1);
    chk("idle drain", out_valid, 0);
    cyc(0, 8'h00, 0, 8'h00, 0);
    chk("idle sel holds i1", sel, 1);
    cyc(0, 8'h00, 1, 8'hA5, 1);
    chk("single i1 data", out_data, 8'hA5);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 3) != 0));
`ifdef RR_MUX_ARBITER_STATS_EN
    chk("cnt0", cnt0, m_c0);
    chk("cnt1", cnt1, m_c1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Two-input round-robin arbiter with valid/ready handshakes. It sits directly upstream of the 2:1 datapath mux and drives that mux's select line.
- It also registers the selected word into a single-entry output stage so downstream logic sees clean, stable data.
- Latency is 1 cycle from handshake to output; with back-to-back traffic, throughput is 1 word per cycle.

Parameters:
- WIDTH, 8, data width of each input and of the output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- i0_valid  input  1  source 0 has data
- i0_data  input  WIDTH  source 0 payload
- i0_ready  output  1  source 0 word accepted this cycle
- i1_valid  input  1  source 1 has data
- i1_data  input  WIDTH  source 1 payload
- i1_ready  output  1  source 1 word accepted this cycle
- sel  output  1  combinational grant; 0 selects i0, 1 selects i1; feeds mux select
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected payload
- out_src  output  1  index of the source that supplied out_data
- out_ready  input  1  downstream consumes out_data when out_valid=1

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, internal last_grant=1. The first contended grant therefore goes to i0.
- accept = !out_valid || out_ready. The output stage can load in the same cycle it drains.
- Grant (combinational):
  - Only i0_valid high: grant 0.
  - Only i1_valid high: grant 1.
  - Both high: grant = ~last_grant.
  - Neither high: sel holds last_grant, so the mux input stays stable.
- sel = grant.
- i0_ready = accept && i0_valid && grant==0. i1_ready = accept && i1_valid && grant==1. The two readies are never both high.
- On a clock edge with a handshake (ix_valid && ix_ready):
  - out_data <= selected data.
  - out_src <= grant.
  - out_valid <= 1.
  - last_grant <= grant.
- On a clock edge with no handshake and out_ready=1: out_valid <= 0. out_data and out_src hold their values.
- When out_valid=1 and out_ready=0: all output registers hold, both readies are 0, and last_grant is unchanged.
- A held grant is not re-evaluated away from a waiting source, because last_grant only updates on a handshake. Starvation is therefore bounded to 1 word.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old word in that cycle.
- Reset asserted mid-transfer: any in-flight output word is discarded, and arbitration restarts with i0 priority.
- Inputs are sampled only through the handshake. Values of x or z on an invalid source have no effect on the outputs.

Optional Feature:
- Macro: RR_MUX_ARBITER_STATS_EN.
- When defined, two extra output ports are added: cnt0 and cnt1, each 16 bits. Each counts the handshakes accepted from its source.
  - Both reset to 0.
  - Each wraps from 0xFFFF to 0x0000.
  - Each increments in the same edge as the corresponding out_data load.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rr_mux_pkg holds:
  - SRC_I0=1'b0 and SRC_I1=1'b1 constants.
  - Default WIDTH constant.
  - Counter width constant STATS_W=16.
- One natural sub-module, rr_grant, holds the combinational grant logic plus the last_grant flop.
- The top level holds the accept logic and the output register.

Test Plan:
- Reset: assert rst mid-cycle -> out_valid=0, out_data=0, out_src=0 immediately. After release, with both valid, sel=0 and i0_ready=1.
- Single source: i1_valid=1, i1_data=8'hA5, out_ready=1 -> next edge out_valid=1, out_data=A5, out_src=1.
- Contention: both valid continuously with i0_data=11, i1_data=22, out_ready=1 -> outputs alternate 11,22,11,22 with out_src 0,1,0,1, one word per cycle.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> out_data held, i0_ready=i1_ready=0. On out_ready=1, the same-edge reload accepts the granted source.
- Idle: both valid=0 after a grant to i1 -> sel remains 1 and out_valid drops after the drain.
- Stats (with RR_MUX_ARBITER_STATS_EN): 5 handshakes from i0 and 3 from i1 -> cnt0=5, cnt1=3. Preload to 0xFFFF plus one more i0 handshake -> cnt0=0.
